pixel_window_fetch: RTL and testbench

Fetches one 3x3 pixel window from image SRAM for the edge-detection datapath, sitting directly downstream of `address_counter`. For each of the 9 pixels it:
- pulses the counter's read-increment input,
- waits for the counter's read-ready,
- issues a single-cycle SRAM read at the presented address,
- captures the returned pixel.

After 9 pixels it presents the packed window to the gradient stage with a valid/ack handshake.

---
 rtl/window_fetch_pkg.sv | 17 +
 rtl/pixel_window_reg.sv | 37 +++
 rtl/pixel_window_fetch.sv | 141 ++++++++++++++
 tb/tb_pixel_window_fetch.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/window_fetch_pkg.sv
// Shared types and constants for the 3x3 pixel window fetcher.
// Holds the fetch FSM state encoding and window/watchdog sizes.
package window_fetch_pkg;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      WAIT_ADDR,
      MEM_RD,
      WAIT_DATA,
      VALID
   } fetch_state_t;

   localparam int WINDOW_PIXELS = 9;
   localparam int FETCH_TIMEOUT = 255;

endpackage

// File: rtl/pixel_window_reg.sv
// Nine-slot pixel register with indexed write and packed output.
// Slot k lands at bits [k*PIXEL_W +: PIXEL_W] of o_window.
module pixel_window_reg
   import window_fetch_pkg::*;
#(
   parameter int PIXEL_W = 8
) (
   input  logic                             clk,
   input  logic                             n_rst,
   input  logic                             i_we,
   input  logic [3:0]                       i_idx,
   input  logic [PIXEL_W-1:0]               i_data,
   output logic [WINDOW_PIXELS*PIXEL_W-1:0] o_window
);

   logic [PIXEL_W-1:0] r_slot [WINDOW_PIXELS];

   // Write the addressed slot; clear all slots on reset
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         for (int s = 0; s < WINDOW_PIXELS; s++) begin
            r_slot[s] <= '0;
         end
      end else if (i_we) begin
         for (int s = 0; s < WINDOW_PIXELS; s++) begin
            if (i_idx == 4'(s)) begin
               r_slot[s] <= i_data;
            end
         end
      end
   end

   for (genvar g = 0; g < WINDOW_PIXELS; g++) begin : g_pack
      assign o_window[g*PIXEL_W +: PIXEL_W] = r_slot[g];
   end

endmodule

// File: rtl/pixel_window_fetch.sv
// Fetches a 3x3 pixel window via address_counter and image SRAM.
// Define PIXEL_WINDOW_FETCH_TIMEOUT_EN to enable the wait-state watchdog.
module pixel_window_fetch
   import window_fetch_pkg::*;
#(
   parameter int PIXEL_W = 8,
   parameter int ADDR_W  = 32
) (
   input  logic                             clk,
   input  logic                             n_rst,
   input  logic                             i_start,
   output logic                             o_inc_raddr,
   input  logic                             i_r_ready,
   input  logic [ADDR_W-1:0]                i_raddr,
   output logic                             o_mem_ren,
   output logic [ADDR_W-1:0]                o_mem_addr,
   input  logic                             i_mem_rvalid,
   input  logic [PIXEL_W-1:0]               i_mem_rdata,
   output logic [WINDOW_PIXELS*PIXEL_W-1:0] o_window,
   input  logic                             i_window_ack,
   output logic                             o_window_valid,
   output logic                             o_busy,
   output logic                             o_error
);

   localparam logic [3:0] LAST_K = 4'(WINDOW_PIXELS - 1);

   fetch_state_t      r_state;
   logic [3:0]        r_k;
   logic [ADDR_W-1:0] r_addr;
   logic              r_inc;
   logic              r_ren;
   logic              r_valid;
   logic              w_we;

   assign w_we = (r_state == WAIT_DATA) && i_mem_rvalid;

`ifdef PIXEL_WINDOW_FETCH_TIMEOUT_EN
   logic [7:0] r_wd;
   logic       r_error;
   logic       w_stall;
   logic       w_wd_fire;

   assign w_stall = ((r_state == WAIT_ADDR) && !i_r_ready) ||
                    ((r_state == WAIT_DATA) && !i_mem_rvalid);
   assign w_wd_fire = w_stall && (r_wd == 8'(FETCH_TIMEOUT - 1));
`endif

   // Fetch sequencer: one pixel per REQ..WAIT_DATA loop, registered strobes
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         r_state <= IDLE;
         r_k     <= '0;
         r_addr  <= '0;
         r_inc   <= 1'b0;
         r_ren   <= 1'b0;
         r_valid <= 1'b0;
`ifdef PIXEL_WINDOW_FETCH_TIMEOUT_EN
         r_wd    <= '0;
         r_error <= 1'b0;
`endif
      end else begin
         r_inc <= 1'b0;
         r_ren <= 1'b0;
         unique case (r_state)
            IDLE: begin
               if (i_start) begin
                  r_k     <= '0;
                  r_inc   <= 1'b1;
                  r_state <= REQ;
               end
            end
            REQ: r_state <= WAIT_ADDR;
            WAIT_ADDR: begin
               if (i_r_ready) begin
                  r_addr  <= i_raddr;
                  r_ren   <= 1'b1;
                  r_state <= MEM_RD;
               end
            end
            MEM_RD: r_state <= WAIT_DATA;
            WAIT_DATA: begin
               if (i_mem_rvalid) begin
                  if (r_k == LAST_K) begin
                     r_valid <= 1'b1;
                     r_state <= VALID;
                  end else begin
                     r_k     <= r_k + 4'd1;
                     r_inc   <= 1'b1;
                     r_state <= REQ;
                  end
               end
            end
            VALID: begin
               if (i_window_ack) begin
                  r_valid <= 1'b0;
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
`ifdef PIXEL_WINDOW_FETCH_TIMEOUT_EN
         // Watchdog overrides the sequencer when a wait state stalls too long
         if (w_wd_fire) begin
            r_wd    <= '0;
            r_error <= 1'b1;
            r_k     <= '0;
            r_state <= IDLE;
         end else if (w_stall) begin
            r_wd <= r_wd + 8'd1;
         end else begin
            r_wd <= '0;
         end
`endif
      end
   end

   pixel_window_reg #(
      .PIXEL_W (PIXEL_W)
   ) u_win (
      .clk      (clk),
      .n_rst    (n_rst),
      .i_we     (w_we),
      .i_idx    (r_k),
      .i_data   (i_mem_rdata),
      .o_window (o_window)
   );

   assign o_inc_raddr    = r_inc;
   assign o_mem_ren      = r_ren;
   assign o_mem_addr     = r_addr;
   assign o_window_valid = r_valid;
   assign o_busy         = (r_state != IDLE);

`ifdef PIXEL_WINDOW_FETCH_TIMEOUT_EN
   assign o_error = r_error;
`else
   assign o_error = 1'b0;
`endif

endmodule

// File: tb/tb_pixel_window_fetch.sv
// Scoreboard bench for pixel_window_fetch with counter and SRAM models.
// Follows PIXEL_WINDOW_FETCH_TIMEOUT_EN to pick the stall expectations.
module tb_pixel_window_fetch;
   import window_fetch_pkg::*;

   localparam int PW = 8;
   localparam int AW = 32;

   logic           clk = 1'b0;
   logic           n_rst = 1'b0;
   logic           i_start = 1'b0;
   logic           i_r_ready = 1'b0;
   logic [AW-1:0]  i_raddr = '0;
   logic           i_mem_rvalid = 1'b0;
   logic [PW-1:0]  i_mem_rdata = '0;
   logic           i_window_ack = 1'b0;
   logic           o_inc_raddr;
   logic           o_mem_ren;
   logic [AW-1:0]  o_mem_addr;
   logic [9*PW-1:0] o_window;
   logic           o_window_valid;
   logic           o_busy;
   logic           o_error;

   pixel_window_fetch #(.PIXEL_W(PW), .ADDR_W(AW)) dut (
      .clk            (clk),
      .n_rst          (n_rst),
      .i_start        (i_start),
      .o_inc_raddr    (o_inc_raddr),
      .i_r_ready      (i_r_ready),
      .i_raddr        (i_raddr),
      .o_mem_ren      (o_mem_ren),
      .o_mem_addr     (o_mem_addr),
      .i_mem_rvalid   (i_mem_rvalid),
      .i_mem_rdata    (i_mem_rdata),
      .o_window       (o_window),
      .i_window_ack   (i_window_ack),
      .o_window_valid (o_window_valid),
      .o_busy         (o_busy),
      .o_error        (o_error)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   task automatic chk(string nm, logic [71:0] act, logic [71:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Reference: slot k holds the low byte of the k-th address handed out
   function automatic logic [71:0] exp_win(logic [31:0] base);
      logic [71:0] w;
      logic [31:0] a;
      w = '0;
      for (int k = 0; k < 9; k++) begin
         a = base + 32'(k);
         w[k*8 +: 8] = a[7:0];
      end
      return w;
   endfunction

   logic [71:0] sbq[$];

   // Models of address_counter and SRAM, plus fault injection
   int          a_lat = 4;
   int          m_lat = 1;
   int          a_pend = 0;
   int          m_pend = 0;
   logic [31:0] next_addr = 32'd100;
   logic [31:0] m_addr = '0;
   int          inc_count = 0;
   bit          hold_ready = 0;
   bit          spur_req = 0;

   initial begin
      forever begin
         @(posedge clk);
         #1;
         i_r_ready    = 1'b0;
         i_mem_rvalid = 1'b0;
         i_mem_rdata  = '0;
         if (!n_rst) begin
            a_pend = 0;
            m_pend = 0;
         end else begin
            if (a_pend > 0) begin
               a_pend--;
               if (a_pend == 0) begin
                  if (hold_ready) begin
                     a_pend = 1;
                  end else begin
                     i_r_ready = 1'b1;
                     i_raddr   = next_addr;
                     next_addr = next_addr + 32'd1;
                  end
               end
            end
            if (o_inc_raddr) begin
               inc_count++;
               a_pend = a_lat;
            end
            if (m_pend > 0) begin
               m_pend--;
               if (m_pend == 0) begin
                  i_mem_rvalid = 1'b1;
                  i_mem_rdata  = m_addr[7:0];
               end
            end
            if (o_mem_ren) begin
               m_pend = m_lat;
               m_addr = o_mem_addr;
            end
            if (spur_req && a_pend > 0 && !o_inc_raddr &&
                !i_r_ready && m_pend == 0) begin
               i_mem_rvalid = 1'b1;
               i_mem_rdata  = 8'hFF;
               spur_req     = 0;
            end
         end
      end
   end

   // Monitor: each new window is checked against the scoreboard head
   bit mon_prev = 0;
   initial begin
      forever begin
         @(negedge clk);
         if (o_window_valid && !mon_prev) begin
            if (sbq.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_window: got %h expected none",
                        o_window);
            end else begin
               chk("window", o_window, sbq.pop_front());
            end
         end
         mon_prev = o_window_valid;
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic start_fetch();
      sbq.push_back(exp_win(next_addr));
      i_start = 1'b1;
      cyc();
      i_start = 1'b0;
   endtask

   task automatic check_idle_zero(string nm);
      chk({nm, "_inc"}, 72'(o_inc_raddr), 72'(0));
      chk({nm, "_ren"}, 72'(o_mem_ren), 72'(0));
      chk({nm, "_addr"}, 72'(o_mem_addr), 72'(0));
      chk({nm, "_win"}, o_window, 72'(0));
      chk({nm, "_valid"}, 72'(o_window_valid), 72'(0));
      chk({nm, "_busy"}, 72'(o_busy), 72'(0));
      chk({nm, "_err"}, 72'(o_error), 72'(0));
   endtask

   task automatic do_fetch(string nm, int al, int ml, bit spur,
                           int hold, bit start_ack, int exp_cyc);
      int          cycles;
      int          base_inc;
      bit          stable;
      bit          no_ff;
      logic [71:0] w0;
      a_lat    = al;
      m_lat    = ml;
      spur_req = spur;
      base_inc = inc_count;
      start_fetch();
      cycles = 0;
      while (!o_window_valid && cycles < 3000) begin
         if (spur) i_start = 1'($urandom_range(0, 1));
         cyc();
         cycles++;
      end
      i_start = 1'b0;
      chk({nm, "_valid_seen"}, 72'(o_window_valid), 72'(1));
      if (!o_window_valid) begin
         spur_req = 0;
         return;
      end
      if (exp_cyc > 0) chk({nm, "_latency"}, 72'(cycles), 72'(exp_cyc));
      chk({nm, "_pulses"}, 72'(inc_count - base_inc), 72'(9));
      if (spur) begin
         no_ff = 1;
         for (int k = 0; k < 9; k++) begin
            if (o_window[k*8 +: 8] == 8'hFF) no_ff = 0;
         end
         chk({nm, "_no_ff"}, 72'(no_ff), 72'(1));
      end
      w0 = o_window;
      stable = 1;
      for (int i = 0; i < hold; i++) begin
         cyc();
         if (!o_window_valid || o_window !== w0) stable = 0;
      end
      if (hold > 0) chk({nm, "_hold"}, 72'(stable), 72'(1));
      i_window_ack = 1'b1;
      i_start      = start_ack;
      cyc();
      i_window_ack = 1'b0;
      i_start      = 1'b0;
      chk({nm, "_valid_fall"}, 72'(o_window_valid), 72'(0));
      chk({nm, "_busy_idle"}, 72'(o_busy), 72'(0));
      cyc();
      chk({nm, "_no_restart"}, 72'({o_inc_raddr, o_busy}), 72'(0));
      spur_req = 0;
   endtask

   initial begin
      int          base_inc;
      int          n;
      bit          never_valid;
      logic [31:0] hi;

      n_rst = 1'b0;
      repeat (3) cyc();
      check_idle_zero("reset");
      n_rst = 1'b1;
      cyc();

      next_addr = 32'd100;
      do_fetch("basic", 4, 1, 0, 10, 0, 63);
      chk("basic_const", exp_win(32'd100), 72'h6C6B6A6968676665_64);

      next_addr = 32'd40;
      do_fetch("spur", 3, 2, 1, 2, 1, 0);

      next_addr = 32'd120;
      a_lat     = 2;
      m_lat     = 1;
      base_inc  = inc_count;
      start_fetch();
      n = 0;
      while (inc_count - base_inc < 5 && n < 500) begin
         cyc();
         n++;
      end
      chk("midrst_reached", 72'(inc_count - base_inc), 72'(5));
      n_rst = 1'b0;
      cyc();
      check_idle_zero("midrst");
      sbq.delete();
      cyc();
      n_rst = 1'b1;
      cyc();
      do_fetch("after_rst", 2, 1, 0, 1, 0, 0);

      for (int t = 0; t < 6; t++) begin
         hi        = $urandom;
         next_addr = {hi[31:8], 8'($urandom_range(0, 200))};
         do_fetch("rand", $urandom_range(1, 6), $urandom_range(1, 4),
                  1'($urandom_range(0, 1)), $urandom_range(0, 5),
                  1'($urandom_range(0, 1)), 0);
      end

      next_addr  = 32'd60;
      a_lat      = 2;
      m_lat      = 1;
      hold_ready = 1;
      base_inc   = inc_count;
      start_fetch();
      never_valid = 1;
`ifdef PIXEL_WINDOW_FETCH_TIMEOUT_EN
      for (int i = 0; i < 255; i++) begin
         cyc();
         if (o_window_valid) never_valid = 0;
      end
      chk("wd_pre_err", 72'({o_error, o_busy}), 72'(2'b01));
      cyc();
      chk("wd_err", 72'({o_error, o_busy, o_window_valid}), 72'(3'b100));
      hold_ready = 0;
      repeat (20) begin
         cyc();
         if (o_window_valid) never_valid = 0;
      end
      chk("wd_never_valid", 72'(never_valid), 72'(1));
      void'(sbq.pop_front());
      chk("wd_sticky", 72'(o_error), 72'(1));
`else
      for (int i = 0; i < 1000; i++) begin
         cyc();
         if (o_window_valid || o_mem_ren) never_valid = 0;
      end
      chk("stall_waiting", 72'({o_error, o_busy}), 72'(2'b01));
      chk("stall_quiet", 72'(never_valid), 72'(1));
      chk("stall_pulses", 72'(inc_count - base_inc), 72'(1));
      hold_ready = 0;
      n = 0;
      while (!o_window_valid && n < 500) begin
         cyc();
         n++;
      end
      chk("stall_resume", 72'(o_window_valid), 72'(1));
      i_window_ack = 1'b1;
      cyc();
      i_window_ack = 1'b0;
`endif

      n_rst = 1'b0;
      repeat (2) cyc();
      check_idle_zero("final_rst");
      n_rst = 1'b1;
      repeat (3) cyc();
      chk("sb_empty", 72'(sbq.size()), 72'(0));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
